// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM state encoding, frame geometry and
// the odd-parity helper used by the deframer.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam int unsigned PS2_FRAME_BITS = 11;
   localparam int unsigned PS2_DATA_BITS  = 8;

   // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] i_data,
                                          input logic                     i_par);
      return ^{i_data, i_par};
   endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// PS/2 pad front end: 2-FF synchronisers for clock and data, optional glitch
// filter on the clock (PS2_RX_GLITCH_FILTER_EN), and a registered falling-edge
// strobe with the data bit sampled on that edge.
module ps2_sync_filter
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_ps2_clk,
   input  logic i_ps2_dat,
   output logic o_edge,
   output logic o_bit
);

   logic r_clk_s1, r_clk_s2;
   logic r_dat_s1, r_dat_s2;
   logic r_filt_prev;
   logic r_edge;
   logic r_bit;
   logic w_filt;

   // Two-stage synchronisers; idle bus level is high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= i_ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= i_ps2_dat;
         r_dat_s2 <= r_dat_s1;
      end
   end

`ifdef PS2_RX_GLITCH_FILTER_EN
   localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

   logic [CNT_W-1:0] r_flt_cnt;
   logic             r_flt;

   // Flip the filtered level only after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_flt_cnt <= '0;
         r_flt     <= 1'b1;
      end else if (r_clk_s2 == r_flt) begin
         r_flt_cnt <= '0;
      end else if (r_flt_cnt == CNT_W'(FILTER_LEN - 1)) begin
         r_flt_cnt <= '0;
         r_flt     <= ~r_flt;
      end else begin
         r_flt_cnt <= r_flt_cnt + 1'b1;
      end
   end

   assign w_filt = r_flt;
`else
   logic w_unused_filter_len;

   assign w_unused_filter_len = ^FILTER_LEN;
   assign w_filt              = r_clk_s2;
`endif

   // Registered falling-edge strobe; data is captured alongside it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_filt_prev <= 1'b1;
         r_edge      <= 1'b0;
         r_bit       <= 1'b1;
      end else begin
         r_filt_prev <= w_filt;
         r_edge      <= r_filt_prev & ~w_filt;
         if (r_filt_prev & ~w_filt) begin
            r_bit <= r_dat_s2;
         end
      end
   end

   assign o_edge = r_edge;
   assign o_bit  = r_bit;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames (start, 8 data LSB first,
// odd parity, stop), emits a one-cycle write strobe with the scancode, or a
// one-cycle error strobe on bad parity, bad stop bit or a stalled frame.
// Optional glitch filter on the PS/2 clock: define PS2_RX_GLITCH_FILTER_EN.
module ps2_key_rx
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN  = 8,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic                     CLK,
   input  logic                     RST_X,
   input  logic                     w_ps2_clk,
   input  logic                     w_ps2_dat,
   output logic                     w_key_we,
   output logic [PS2_DATA_BITS-1:0] w_key_data,
   output logic                     w_err
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

   ps2_state_e               r_state, w_state_d;
   logic [2:0]               r_bitcnt, w_bitcnt_d;
   logic [PS2_DATA_BITS-1:0] r_shift, w_shift_d;
   logic                     r_par, w_par_d;
   logic [PS2_DATA_BITS-1:0] r_key_data, w_key_data_d;
   logic                     r_key_we, w_key_we_d;
   logic                     r_err, w_err_d;
   logic [TO_W-1:0]          r_to_cnt;
   logic                     w_edge;
   logic                     w_bit;
   logic                     w_timeout;

   ps2_sync_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_sync_filter (
      .i_clk     (CLK),
      .i_rst_n   (RST_X),
      .i_ps2_clk (w_ps2_clk),
      .i_ps2_dat (w_ps2_dat),
      .o_edge    (w_edge),
      .o_bit     (w_bit)
   );

   // Stall timer: runs only while a frame is open, saturates at TIMEOUT_CYC.
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_to_cnt <= '0;
      end else if (w_edge || (r_state == IDLE)) begin
         r_to_cnt <= '0;
      end else if (r_to_cnt != TO_W'(TIMEOUT_CYC)) begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_state != IDLE) && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

   // Next-state and output decode; an edge takes priority over a timeout.
   always_comb begin
      w_state_d    = r_state;
      w_bitcnt_d   = r_bitcnt;
      w_shift_d    = r_shift;
      w_par_d      = r_par;
      w_key_data_d = r_key_data;
      w_key_we_d   = 1'b0;
      w_err_d      = 1'b0;
      if (w_edge) begin
         unique case (r_state)
            IDLE: begin
               if (!w_bit) begin
                  w_state_d  = DATA;
                  w_bitcnt_d = 3'd0;
               end
            end
            DATA: begin
               w_shift_d  = {w_bit, r_shift[PS2_DATA_BITS-1:1]};
               w_bitcnt_d = r_bitcnt + 3'd1;
               if (r_bitcnt == 3'd7) begin
                  w_state_d = PARITY;
               end
            end
            PARITY: begin
               w_par_d   = w_bit;
               w_state_d = STOP;
            end
            STOP: begin
               if (odd_parity_ok(r_shift, r_par) && w_bit) begin
                  w_key_data_d = r_shift;
                  w_key_we_d   = 1'b1;
               end else begin
                  w_err_d = 1'b1;
               end
               w_state_d = IDLE;
            end
         endcase
      end else if (w_timeout) begin
         w_state_d  = IDLE;
         w_bitcnt_d = 3'd0;
         w_err_d    = 1'b1;
      end
   end

   // FSM state, shift register and registered outputs.
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_state    <= IDLE;
         r_bitcnt   <= 3'd0;
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_key_data <= '0;
         r_key_we   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_bitcnt   <= w_bitcnt_d;
         r_shift    <= w_shift_d;
         r_par      <= w_par_d;
         r_key_data <= w_key_data_d;
         r_key_we   <= w_key_we_d;
         r_err      <= w_err_d;
      end
   end

   assign w_key_we   = r_key_we;
   assign w_key_data = r_key_data;
   assign w_err      = r_err;

endmodule

// File: doc/ps2_key_rx.md
# ps2_key_rx

Receives the PS/2 keyboard serial stream and delivers each scancode byte as a one-cycle write strobe plus data. It sits directly upstream of the keystroke debug recorder, which stores each byte with a timestamp into its capture buffer. The block synchronises and filters the asynchronous PS/2 clock, deframes 11-bit frames, checks odd parity and stop bit, and aborts stalled frames with a timeout.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive identical samples required before the filtered PS/2 clock changes level.
- TIMEOUT_CYC, 50000: CLK cycles without a PS/2 falling edge before an open frame is abandoned.

Ports:
- CLK  input  1  system clock; the single clock of the block.
- RST_X  input  1  reset; asynchronous, active-low.
- w_ps2_clk  input  1  raw PS/2 clock from the pad, asynchronous.
- w_ps2_dat  input  1  raw PS/2 data from the pad, asynchronous.
- w_key_we  output  1  one-cycle strobe: valid byte on w_key_data.
- w_key_data  output  8  received scancode; held until the next valid byte.
- w_err  output  1  one-cycle strobe: parity, stop-bit or timeout error.

## Operation
- Both pad inputs pass through 2-FF synchronisers; reset value 1.
- Filtered clock: a counter increments while the synchronised clock differs from the filtered level and clears when it matches. At FILTER_LEN the filtered level flips. Reset level is 1.
- Falling edge: filtered level changes 1→0. The synchronised data bit is sampled on that cycle.
- FSM states:
  - IDLE → DATA on an edge with data=0 (start bit). An edge with data=1 stays in IDLE with no error.
  - DATA → after 8 edges, bits shift in LSB first → PARITY.
  - PARITY → edge: capture the parity bit → STOP.
  - STOP → edge:
    - If XOR of 8 data bits and parity bit is 1 and stop bit is 1: update w_key_data and pulse w_key_we.
    - Otherwise pulse w_err and leave w_key_data unchanged.
    - Return to IDLE in either case.
- Timeout counter:
  - Clears on every falling edge and while in IDLE; otherwise increments, saturating.
  - Reaching TIMEOUT_CYC-1 in any non-IDLE state forces IDLE, clears the bit counter and pulses w_err.
- If a timeout and an edge occur on the same cycle, the edge wins: it is processed and the counter clears.
- w_key_we and w_err are never asserted together.
- Reset values: w_key_we=0, w_err=0, w_key_data=8'h00, state IDLE, all counters 0.
- Reset asserted mid-frame discards the partial frame immediately. After reset release, the first start bit begins a new frame.
- The PS/2 host-to-device direction (inhibit and transmit) is not supported; both pad inputs are input-only.

## Timing
- Edge-detect latency from the raw falling edge: 2 synchroniser cycles plus FILTER_LEN cycles, plus 1 cycle, when the filter is compiled in.
- w_key_we and w_key_data are registered. The strobe is asserted on the cycle after the stop-bit edge is detected.
- Minimum spacing between strobes is one PS/2 frame, so no backpressure is needed. The downstream block must accept a strobe on any cycle.
- Bit counter is 3 bits wide; the wrap from 7 marks the transition to PARITY.
- Timeout counter width is $clog2(TIMEOUT_CYC+1).

## Configuration
- PS2_RX_GLITCH_FILTER_EN defined: the FILTER_LEN counter filter is present as described above.
- PS2_RX_GLITCH_FILTER_EN undefined:
  - The filtered clock equals the synchronised clock directly, and FILTER_LEN is ignored.
  - Edge latency becomes 3 cycles.
  - A single-cycle glitch on the pad clock produces a spurious edge.

## Structure
- Shared package ps2_pkg holds:
  - FSM state encoding constants: IDLE, DATA, PARITY, STOP.
  - PS2_FRAME_BITS=11 and PS2_DATA_BITS=8.
- Sub-module ps2_sync_filter contains:
  - the 2-FF synchronisers for clock and data;
  - the glitch filter, under the PS2_RX_GLITCH_FILTER_EN guard;
  - the falling-edge detector.
- It outputs a sampled-data bit and an edge strobe. The FSM, timeout counter and output registers live in ps2_key_rx.

## Test plan
- Frame 0x1C, parity 0, stop 1, at a 12.5 kHz PS/2 clock: exactly one w_key_we, w_key_data=8'h1C, w_err stays 0.
- Back-to-back frames 0xF0 (parity 1) then 0x1C: two strobes carrying F0 then 1C, and w_key_data holds 1C afterwards.
- Frame 0x1C with parity bit 1: one w_err pulse, no w_key_we, w_key_data retains its previous value.
- Start bit plus 4 data bits, then the clock is held high for TIMEOUT_CYC cycles: one w_err pulse, FSM in IDLE, and a following valid 0x1C frame is received correctly.
- Filter enabled, 3-cycle low glitches injected on w_ps2_clk between bits of frame 0x1C: data is still 8'h1C with no error. With the filter disabled, the same stimulus produces w_err or corrupted data.
- RST_X pulsed low mid-frame: outputs reset to 0 asynchronously, and the next full frame 0x5A (parity 1) yields w_key_data=8'h5A.
